// File: rtl/apb_ucpd_tx_enc.sv
// -----------------------------------------------------------------------------
// apb_ucpd_tx_enc
//
// USB Power Delivery transmit bit encoder. Turns the one-hot TX phase selected
// by the main FSM (preamble, SOP ordered set, 4b5b payload, CRC-32, EOP) into
// one raw bit per bit period, and produces the BMC line level for the CC
// driver. Also keeps the running CRC-32 over the payload bytes.
//
// Optional feature:
//   UCPD_TX_BIST_EN  When defined, bist_en sends the BIST carrier (1,0,1,0...).
//                    When undefined, bist_en is ignored and the line stays idle.
//
// Ports:
//   ic_clk        in   kernel clock, all flops on rising edge
//   ic_rst_n      in   synchronous active-low reset
//   ucpden        in   peripheral enable, low acts like reset
//   bit_clk_red   in   pulse at start of each bit period
//   bit_clk_fed   in   pulse at middle of each bit period
//   pre_en .. bist_en in one-hot TX phase
//   txfifo_ld_en  in   load tx_data into the byte shifter
//   tx_data[7:0]  in   payload byte
//   tx_ordset[19:0] in SOP ordered set, four K-codes, bit0 sent first
//   cc_out        out  BMC line level
//   tx_bit        out  raw bit of the current bit period
//   crc_val[31:0] out  running CRC-32 register
// -----------------------------------------------------------------------------
module apb_ucpd_tx_enc (
    input  logic        ic_clk,
    input  logic        ic_rst_n,
    input  logic        ucpden,
    input  logic        bit_clk_red,
    input  logic        bit_clk_fed,
    input  logic        pre_en,
    input  logic        sop_en,
    input  logic        data_en,
    input  logic        crc_en,
    input  logic        eop_en,
    input  logic        wait_en,
    input  logic        bist_en,
    input  logic        txfifo_ld_en,
    input  logic [7:0]  tx_data,
    input  logic [19:0] tx_ordset,
    output logic        cc_out,
    output logic        tx_bit,
    output logic [31:0] crc_val
);

    localparam logic [31:0] CrcPoly = 32'hEDB88320;
    localparam logic [4:0]  EopCode = 5'b01101;

    // 4b5b symbol for a nibble, returned MSB..LSB as tabulated.
    function automatic logic [4:0] enc4b5b(input logic [3:0] nib);
        logic [4:0] sym;
        case (nib)
            4'h0:    sym = 5'b11110;
            4'h1:    sym = 5'b01001;
            4'h2:    sym = 5'b10100;
            4'h3:    sym = 5'b10101;
            4'h4:    sym = 5'b01010;
            4'h5:    sym = 5'b01011;
            4'h6:    sym = 5'b01110;
            4'h7:    sym = 5'b01111;
            4'h8:    sym = 5'b10010;
            4'h9:    sym = 5'b10011;
            4'hA:    sym = 5'b10110;
            4'hB:    sym = 5'b10111;
            4'hC:    sym = 5'b11010;
            4'hD:    sym = 5'b11011;
            4'hE:    sym = 5'b11100;
            default: sym = 5'b11101;
        endcase
        return sym;
    endfunction

    // Reflected CRC-32 over one byte, LSB first, unrolled into one cycle.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) begin
                c = (c >> 1) ^ CrcPoly;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    logic        bist_act;
    logic        active;
    logic        red;
    logic        fed;
    logic        crc_rise;
    logic [9:0]  ld_sym;
    logic [31:0] crc_word;
    logic [3:0]  crc_nibble;
    logic [4:0]  crc_sym;
    logic        next_bit;

    logic [9:0]  shifter;
    logic        pre_next;
    logic [4:0]  sop_idx;
    logic [2:0]  eop_idx;
    logic [2:0]  crc_nib;
    logic [2:0]  crc_bit;
    logic [31:0] crc_tx;
    logic        crc_en_d;

`ifdef UCPD_TX_BIST_EN
    logic        bist_next;
    assign bist_act = bist_en;
`else
    logic        unused_bist;
    assign unused_bist = bist_en;
    assign bist_act    = 1'b0;
`endif

    assign active   = pre_en | sop_en | data_en | crc_en | eop_en | bist_act;
    // A coincident mid-bit pulse is swallowed by the start-of-bit pulse.
    assign red      = bit_clk_red;
    assign fed      = bit_clk_fed & ~bit_clk_red;
    assign crc_rise = crc_en & ~crc_en_d;
    assign ld_sym   = {enc4b5b(tx_data[7:4]), enc4b5b(tx_data[3:0])};

    // On the crc_en rising edge the latched copy is not there yet, so the
    // first bit is taken straight from the inverted running CRC.
    always_comb begin
        crc_word   = crc_rise ? ~crc_val : crc_tx;
        crc_nibble = crc_word[{crc_nib, 2'b00} +: 4];
        crc_sym    = enc4b5b(crc_nibble);
    end

    always_comb begin
        next_bit = 1'b0;
        if (pre_en) begin
            next_bit = pre_next;
        end else if (sop_en) begin
            next_bit = tx_ordset[sop_idx];
        end else if (data_en) begin
            // A load on the same edge sends the new symbol's bit0 immediately.
            next_bit = txfifo_ld_en ? ld_sym[0] : shifter[0];
        end else if (crc_en) begin
            next_bit = crc_sym[crc_bit];
        end else if (eop_en) begin
            next_bit = EopCode[eop_idx];
`ifdef UCPD_TX_BIST_EN
        end else if (bist_en) begin
            next_bit = bist_next;
`endif
        end
    end

    always_ff @(posedge ic_clk) begin
        if (!ic_rst_n || !ucpden) begin
            cc_out    <= 1'b0;
            tx_bit    <= 1'b0;
            crc_val   <= 32'hFFFF_FFFF;
            crc_tx    <= 32'h0;
            crc_en_d  <= 1'b0;
            shifter   <= 10'h0;
            pre_next  <= 1'b0;
            sop_idx   <= 5'd0;
            eop_idx   <= 3'd0;
            crc_nib   <= 3'd0;
            crc_bit   <= 3'd0;
`ifdef UCPD_TX_BIST_EN
            bist_next <= 1'b1;
`endif
        end else begin
            crc_en_d <= crc_en;

            // Running CRC: seeded during SOP, frozen while the CRC is sent.
            if (sop_en) begin
                crc_val <= 32'hFFFF_FFFF;
            end else if (txfifo_ld_en && data_en && !crc_en) begin
                crc_val <= crc32_byte(crc_val, tx_data);
            end
            if (crc_rise) begin
                crc_tx <= ~crc_val;
            end

            // Byte shifter, LSB out first.
            if (txfifo_ld_en) begin
                shifter <= (data_en && red) ? {1'b0, ld_sym[9:1]} : ld_sym;
            end else if (data_en && red) begin
                shifter <= {1'b0, shifter[9:1]};
            end

            // Per-phase bit indices; each restarts whenever its phase is off.
            if (!pre_en) begin
                pre_next <= 1'b0;
            end else if (red) begin
                pre_next <= ~pre_next;
            end

            if (!sop_en) begin
                sop_idx <= 5'd0;
            end else if (red) begin
                sop_idx <= (sop_idx == 5'd19) ? 5'd0 : sop_idx + 5'd1;
            end

            if (!crc_en) begin
                crc_nib <= 3'd0;
                crc_bit <= 3'd0;
            end else if (red) begin
                if (crc_bit == 3'd4) begin
                    crc_bit <= 3'd0;
                    crc_nib <= crc_nib + 3'd1;
                end else begin
                    crc_bit <= crc_bit + 3'd1;
                end
            end

            if (!eop_en) begin
                eop_idx <= 3'd0;
            end else if (red) begin
                eop_idx <= (eop_idx == 3'd4) ? 3'd0 : eop_idx + 3'd1;
            end

`ifdef UCPD_TX_BIST_EN
            if (!bist_en) begin
                bist_next <= 1'b1;
            end else if (red) begin
                bist_next <= ~bist_next;
            end
`endif

            // BMC line: transition at every bit start, extra mid-bit
            // transition for a 1. In WAIT the line is parked low.
            if (active) begin
                if (red) begin
                    tx_bit <= next_bit;
                    cc_out <= ~cc_out;
                end else if (fed && tx_bit) begin
                    cc_out <= ~cc_out;
                end
            end else if (wait_en) begin
                tx_bit <= 1'b0;
                if (red) begin
                    cc_out <= 1'b0;
                end
            end else begin
                tx_bit <= 1'b0;
                cc_out <= 1'b0;
            end
        end
    end

endmodule
